mm_splitter: RTL and testbench
==============================

Name: mm_splitter

Overview:
One-to-many MemoryMapped splitter: a single upstream master connects to the s_* port, and the block routes each transaction to one of SLAVES downstream slaves by address window. It is the counterpart of the many-to-one arbitration stage.
- Request and response paths are fully registered, so long interconnect routes are timing-isolated.
- Transactions to unmapped addresses complete locally with a default read value and an error pulse.

Parameters:
AWIDTH, 8, address width
DWIDTH, 8, data width
SLAVES, 2, number of downstream slaves (SLAVES > 1)
BASES, all-zero, [SLAVES-1:0][AWIDTH-1:0] window base per slave
MASKS, all-zero, [SLAVES-1:0][AWIDTH-1:0] window mask per slave
DEFAULT_RDAT, all-ones, [DWIDTH-1:0] read data returned for unmapped reads

Ports:
reset  in  1  synchronous reset, active-low (asserted when 0)
clk  in  1  clock, all logic on rising edge
s_addr  in  AWIDTH  upstream address
s_wreq  in  1  upstream write request
s_wdat  in  DWIDTH  upstream write data
s_rreq  in  1  upstream read request
s_rdat  out  DWIDTH  upstream read data, valid when s_busy=0 with s_rreq=1
s_busy  out  1  upstream not-ready; transaction completes in the cycle s_busy=0
m_addr  out  [SLAVES-1:0][AWIDTH]  per-slave address (same registered value broadcast to all)
m_wreq  out  SLAVES  per-slave write request, at most one bit set
m_wdat  out  [SLAVES-1:0][DWIDTH]  per-slave write data (broadcast)
m_rreq  out  SLAVES  per-slave read request, at most one bit set
m_rdat  in  [SLAVES-1:0][DWIDTH]  per-slave read data, valid in the cycle a slave's m_busy=0
m_busy  in  SLAVES  per-slave not-ready

Behaviour:
- Protocol on both sides: a request is held stable until busy=0 is seen in the same cycle. Read data is valid in that cycle.
- Decode: slave i hits when (addr & MASKS[i]) == BASES[i]. The lowest index wins on overlap. No hit means unmapped.
- FSM states: IDLE, FWD, DONE.
  - IDLE: s_busy=1. If s_wreq|s_rreq, register addr, wdat, wreq, rreq, the one-hot sel and hit. Go to FWD on a hit, otherwise DONE.
  - FWD: m_wreq = sel & wreq, m_rreq = sel & rreq. When m_busy[sel]=0, capture m_rdat[sel] into the rdat register and go to DONE. Otherwise stay in FWD indefinitely (no timeout).
  - DONE: s_busy=0 for exactly one cycle. s_rdat = rdat register, which holds DEFAULT_RDAT if unmapped. err pulses for an unmapped transaction. Next state is IDLE.
- Upstream stimulus is ignored outside IDLE; the master must keep its request stable until completion.
- Latency:
  - Mapped, slave never busy: request at cycle 0, m_*req at cycle 1, s_busy=0 at cycle 2.
  - Each extra slave-busy cycle adds one cycle.
  - Unmapped: s_busy=0 at cycle 1.
- Throughput: back-to-back requests cost 3 cycles each (IDLE, FWD, DONE).
- wreq and rreq both set: both are forwarded to the same slave. The read data is captured as normal.
- Unmapped write: dropped, no m_* activity.
- Reset values (reset=0 at a rising edge):
  - state=IDLE, s_busy=1, s_rdat=0.
  - m_wreq=0, m_rreq=0, m_addr=0, m_wdat=0.
  - Reset mid-FWD drops the transaction; m_*req are low from the next cycle.
- Also output: err  out  1  one-cycle pulse in DONE for an unmapped access; reset 0. This port is listed with the other ports.

Decomposition:
- Package mm_pkg: splitter state enum (IDLE/FWD/DONE) and a decode function taking addr, bases and masks and returning a one-hot select plus hit.
- Sub-module mm_addr_decoder: combinational decode. Parameters AWIDTH, SLAVES, BASES, MASKS; ports addr in, sel out [SLAVES-1:0], hit out. Instantiated once on s_addr.

Test Plan:
SLAVES=3, AWIDTH=8, DWIDTH=8, BASES={0x80,0x40,0x00}, MASKS={0xC0,0xC0,0xC0}, DEFAULT_RDAT=0xEE.
- Write 0x45 data 0xA5, m_busy=0 -> m_wreq=3'b010 with m_addr=0x45, m_wdat=0xA5 at cycle 1; s_busy=0 at cycle 2 only.
- Read 0x83, m_busy[2]=1 for cycles 1-3, m_rdat[2]=0x5A at cycle 4 -> m_rreq=3'b100 for cycles 1-4; s_busy=0 with s_rdat=0x5A at cycle 5.
- Read 0xC1 (unmapped) -> no m_*req asserted; s_busy=0, s_rdat=0xEE, err=1 at cycle 1.
- Back-to-back reads 0x01 then 0x41, slaves return 0x11 and 0x22 -> completions at cycles 2 and 5 with the correct data; never more than one m_rreq bit set.
- reset=0 during FWD of a read to 0x02 -> next cycle m_rreq=0, s_busy=1, s_rdat=0; a fresh request after release completes normally.
- Overlapping windows (BASES[1]=0x00, MASKS[1]=0x00) with access 0x10 -> slave 0 selected.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and address-decode helper for the memory-mapped splitter.
package mm_pkg;

    localparam int unsigned MAX_SLAVES = 16;
    localparam int unsigned MAX_AWIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [MAX_SLAVES-1:0] sel;
        logic                  hit;
    } dec_t;

    // First window (lowest index) whose masked address equals its base wins.
    function automatic dec_t decode(
        input logic [MAX_AWIDTH-1:0]                 addr,
        input logic [MAX_SLAVES-1:0][MAX_AWIDTH-1:0] bases,
        input logic [MAX_SLAVES-1:0][MAX_AWIDTH-1:0] masks,
        input int unsigned                           n
    );
        dec_t d;
        d = '0;
        for (int unsigned i = 0; i < MAX_SLAVES; i++) begin
            if ((i < n) && !d.hit && ((addr & masks[i]) == bases[i])) begin
                d.sel[i] = 1'b1;
                d.hit    = 1'b1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/mm_addr_decoder.sv
// Combinational address-window decoder producing a one-hot slave select.
module mm_addr_decoder
    import mm_pkg::*;
#(
    parameter int unsigned                    AWIDTH = 8,
    parameter int unsigned                    SLAVES = 2,
    parameter logic [SLAVES-1:0][AWIDTH-1:0]  BASES  = '0,
    parameter logic [SLAVES-1:0][AWIDTH-1:0]  MASKS  = '0
) (
    input  logic [AWIDTH-1:0] addr,
    output logic [SLAVES-1:0] sel,
    output logic              hit
);

    logic [MAX_SLAVES-1:0][MAX_AWIDTH-1:0] w_bases;
    logic [MAX_SLAVES-1:0][MAX_AWIDTH-1:0] w_masks;
    dec_t                                  w_dec;
    logic                                  w_unused_sel;

    // Widen the window tables to the helper's fixed table size.
    always_comb begin
        w_bases = '0;
        w_masks = '0;
        for (int unsigned i = 0; i < SLAVES; i++) begin
            w_bases[i] = MAX_AWIDTH'(BASES[i]);
            w_masks[i] = MAX_AWIDTH'(MASKS[i]);
        end
    end

    assign w_dec        = decode(MAX_AWIDTH'(addr), w_bases, w_masks, SLAVES);
    assign sel          = w_dec.sel[SLAVES-1:0];
    assign hit          = w_dec.hit;
    assign w_unused_sel = |w_dec.sel[MAX_SLAVES-1:SLAVES];

endmodule

// File: rtl/mm_splitter.sv
// One-to-many memory-mapped splitter with registered request and response paths.
module mm_splitter
    import mm_pkg::*;
#(
    parameter int unsigned                    AWIDTH       = 8,
    parameter int unsigned                    DWIDTH       = 8,
    parameter int unsigned                    SLAVES       = 2,
    parameter logic [SLAVES-1:0][AWIDTH-1:0]  BASES        = '0,
    parameter logic [SLAVES-1:0][AWIDTH-1:0]  MASKS        = '0,
    parameter logic [DWIDTH-1:0]              DEFAULT_RDAT = '1
) (
    input  logic                          reset,
    input  logic                          clk,
    input  logic [AWIDTH-1:0]             s_addr,
    input  logic                          s_wreq,
    input  logic [DWIDTH-1:0]             s_wdat,
    input  logic                          s_rreq,
    output logic [DWIDTH-1:0]             s_rdat,
    output logic                          s_busy,
    output logic                          err,
    output logic [SLAVES-1:0][AWIDTH-1:0] m_addr,
    output logic [SLAVES-1:0]             m_wreq,
    output logic [SLAVES-1:0][DWIDTH-1:0] m_wdat,
    output logic [SLAVES-1:0]             m_rreq,
    input  logic [SLAVES-1:0][DWIDTH-1:0] m_rdat,
    input  logic [SLAVES-1:0]             m_busy
);

    state_t              r_state, w_state_nxt;
    logic [AWIDTH-1:0]   r_addr,  w_addr_nxt;
    logic [DWIDTH-1:0]   r_wdat,  w_wdat_nxt;
    logic                r_wreq,  w_wreq_nxt;
    logic                r_rreq,  w_rreq_nxt;
    logic [SLAVES-1:0]   r_sel,   w_sel_nxt;
    logic                r_hit,   w_hit_nxt;
    logic [DWIDTH-1:0]   r_rdat,  w_rdat_nxt;
    logic                r_busy,  w_busy_nxt;
    logic                r_err,   w_err_nxt;
    logic [SLAVES-1:0]   r_mwreq, w_mwreq_nxt;
    logic [SLAVES-1:0]   r_mrreq, w_mrreq_nxt;

    logic [SLAVES-1:0]   w_dec_sel;
    logic                w_dec_hit;
    logic                w_sel_busy;
    logic [DWIDTH-1:0]   w_sel_rdat;

    mm_addr_decoder #(
        .AWIDTH (AWIDTH),
        .SLAVES (SLAVES),
        .BASES  (BASES),
        .MASKS  (MASKS)
    ) u_dec (
        .addr (s_addr),
        .sel  (w_dec_sel),
        .hit  (w_dec_hit)
    );

    // Busy and read data of the currently selected slave.
    assign w_sel_busy = |(r_sel & m_busy);

    always_comb begin
        w_sel_rdat = '0;
        for (int unsigned i = 0; i < SLAVES; i++) begin
            if (r_sel[i]) begin
                w_sel_rdat = w_sel_rdat | m_rdat[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, captured transaction and next registered outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_wdat_nxt  = r_wdat;
        w_wreq_nxt  = r_wreq;
        w_rreq_nxt  = r_rreq;
        w_sel_nxt   = r_sel;
        w_hit_nxt   = r_hit;
        w_rdat_nxt  = r_rdat;

        case (r_state)
            IDLE: begin
                if (s_wreq || s_rreq) begin
                    w_addr_nxt = s_addr;
                    w_wdat_nxt = s_wdat;
                    w_wreq_nxt = s_wreq;
                    w_rreq_nxt = s_rreq;
                    w_sel_nxt  = w_dec_sel;
                    w_hit_nxt  = w_dec_hit;
                    if (w_dec_hit) begin
                        w_state_nxt = FWD;
                    end else begin
                        w_rdat_nxt  = DEFAULT_RDAT;
                        w_state_nxt = DONE;
                    end
                end
            end
            FWD: begin
                if (!w_sel_busy) begin
                    w_rdat_nxt  = w_sel_rdat;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Outputs are registered, so derive them from the upcoming state.
        w_busy_nxt  = (w_state_nxt != DONE);
        w_err_nxt   = (w_state_nxt == DONE) && !w_hit_nxt;
        w_mwreq_nxt = (w_state_nxt == FWD) ? (w_sel_nxt & {SLAVES{w_wreq_nxt}}) : '0;
        w_mrreq_nxt = (w_state_nxt == FWD) ? (w_sel_nxt & {SLAVES{w_rreq_nxt}}) : '0;
    end

    // Transaction and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr  <= '0;
            r_wdat  <= '0;
            r_wreq  <= 1'b0;
            r_rreq  <= 1'b0;
            r_sel   <= '0;
            r_hit   <= 1'b0;
            r_rdat  <= '0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_mwreq <= '0;
            r_mrreq <= '0;
        end else begin
            r_addr  <= w_addr_nxt;
            r_wdat  <= w_wdat_nxt;
            r_wreq  <= w_wreq_nxt;
            r_rreq  <= w_rreq_nxt;
            r_sel   <= w_sel_nxt;
            r_hit   <= w_hit_nxt;
            r_rdat  <= w_rdat_nxt;
            r_busy  <= w_busy_nxt;
            r_err   <= w_err_nxt;
            r_mwreq <= w_mwreq_nxt;
            r_mrreq <= w_mrreq_nxt;
        end
    end

    assign s_rdat = r_rdat;
    assign s_busy = r_busy;
    assign err    = r_err;
    assign m_addr = {SLAVES{r_addr}};
    assign m_wdat = {SLAVES{r_wdat}};
    assign m_wreq = r_mwreq;
    assign m_rreq = r_mrreq;

endmodule

// File: tb/tb_mm_splitter.sv
// Self-checking bench for mm_splitter: directed cases plus randomized transactions.
module tb_mm_splitter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned NS = 3;

    localparam logic [NS-1:0][AW-1:0] BASES1 = {8'h80, 8'h40, 8'h00};
    localparam logic [NS-1:0][AW-1:0] MASKS1 = {8'hC0, 8'hC0, 8'hC0};
    localparam logic [NS-1:0][AW-1:0] BASES2 = {8'h80, 8'h00, 8'h00};
    localparam logic [NS-1:0][AW-1:0] MASKS2 = {8'hC0, 8'h00, 8'hC0};
    localparam logic [DW-1:0]         DEF_RD = 8'hEE;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;

    logic [AW-1:0]         s_addr;
    logic                  s_wreq, s_rreq;
    logic [DW-1:0]         s_wdat, s_rdat;
    logic                  s_busy, err;
    logic [NS-1:0][AW-1:0] m_addr;
    logic [NS-1:0]         m_wreq, m_rreq, m_busy;
    logic [NS-1:0][DW-1:0] m_wdat, m_rdat;

    logic [AW-1:0]         s2_addr;
    logic                  s2_wreq, s2_rreq;
    logic [DW-1:0]         s2_wdat, s2_rdat;
    logic                  s2_busy, err2;
    logic [NS-1:0][AW-1:0] m2_addr;
    logic [NS-1:0]         m2_wreq, m2_rreq, m2_busy;
    logic [NS-1:0][DW-1:0] m2_wdat, m2_rdat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mm_splitter #(
        .AWIDTH (AW), .DWIDTH (DW), .SLAVES (NS),
        .BASES (BASES1), .MASKS (MASKS1), .DEFAULT_RDAT (DEF_RD)
    ) dut (
        .reset (reset), .clk (clk),
        .s_addr (s_addr), .s_wreq (s_wreq), .s_wdat (s_wdat), .s_rreq (s_rreq),
        .s_rdat (s_rdat), .s_busy (s_busy), .err (err),
        .m_addr (m_addr), .m_wreq (m_wreq), .m_wdat (m_wdat), .m_rreq (m_rreq),
        .m_rdat (m_rdat), .m_busy (m_busy)
    );

    mm_splitter #(
        .AWIDTH (AW), .DWIDTH (DW), .SLAVES (NS),
        .BASES (BASES2), .MASKS (MASKS2), .DEFAULT_RDAT (DEF_RD)
    ) dut2 (
        .reset (reset), .clk (clk),
        .s_addr (s2_addr), .s_wreq (s2_wreq), .s_wdat (s2_wdat), .s_rreq (s2_rreq),
        .s_rdat (s2_rdat), .s_busy (s2_busy), .err (err2),
        .m_addr (m2_addr), .m_wreq (m2_wreq), .m_wdat (m2_wdat), .m_rreq (m2_rreq),
        .m_rdat (m2_rdat), .m_busy (m2_busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference decode for the main instance: four 64-byte windows, the top one unmapped.
    function automatic int ref_slave(input logic [7:0] a);
        int win;
        win = int'(a) / 64;
        return (win >= 3) ? -1 : win;
    endfunction

    function automatic logic [NS-1:0][DW-1:0] rand_rdat();
        return {8'($urandom), 8'($urandom), 8'($urandom)};
    endfunction

    // Run one upstream transaction starting in the current cycle (state must be idle).
    task automatic txn(input logic [7:0] a, input logic w, input logic r,
                       input logic [7:0] wd, input int nb, input logic [7:0] rv);
        int            s;
        logic [NS-1:0] oh;
        s  = ref_slave(a);
        oh = (s < 0) ? 3'b000 : 3'(1 << s);
        s_addr = a; s_wreq = w; s_rreq = r; s_wdat = wd;
        m_busy = 3'($urandom);
        m_rdat = rand_rdat();
        chk("idle_busy", 8'(s_busy), 8'd1);
        if (s < 0) begin
            next_cycle();
            chk("unmap_busy", 8'(s_busy), 8'd0);
            chk("unmap_err", 8'(err), 8'd1);
            chk("unmap_wreq", 8'(m_wreq), 8'd0);
            chk("unmap_rreq", 8'(m_rreq), 8'd0);
            if (r) chk("unmap_rdat", s_rdat, DEF_RD);
        end else begin
            for (int c = 1; c <= nb + 2; c++) begin
                next_cycle();
                m_busy = 3'($urandom);
                m_rdat = rand_rdat();
                if (c <= nb + 1) begin
                    m_busy[s] = (c <= nb);
                    if (c == nb + 1) m_rdat[s] = rv;
                    chk("fwd_busy", 8'(s_busy), 8'd1);
                    chk("fwd_err", 8'(err), 8'd0);
                    chk("fwd_wreq", 8'(m_wreq), 8'(w ? oh : 3'b000));
                    chk("fwd_rreq", 8'(m_rreq), 8'(r ? oh : 3'b000));
                    chk("fwd_addr", m_addr[s], a);
                    chk("fwd_wdat", m_wdat[s], wd);
                end else begin
                    chk("done_busy", 8'(s_busy), 8'd0);
                    chk("done_err", 8'(err), 8'd0);
                    chk("done_wreq", 8'(m_wreq), 8'd0);
                    chk("done_rreq", 8'(m_rreq), 8'd0);
                    if (r) chk("done_rdat", s_rdat, rv);
                end
            end
        end
        next_cycle();
        s_wreq = 1'b0; s_rreq = 1'b0; m_busy = '0;
        chk("after_busy", 8'(s_busy), 8'd1);
        chk("after_err", 8'(err), 8'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a2_tab [3];
        int         s2_tab [3];
        logic [7:0] ra, rw, rv;
        int         kind, nb;

        s_addr = '0; s_wreq = 1'b0; s_rreq = 1'b0; s_wdat = '0;
        m_busy = '0; m_rdat = '0;
        s2_addr = '0; s2_wreq = 1'b0; s2_rreq = 1'b0; s2_wdat = '0;
        m2_busy = '0; m2_rdat = '0;

        // Reset values.
        reset = 1'b0;
        next_cycle();
        next_cycle();
        chk("rst_busy", 8'(s_busy), 8'd1);
        chk("rst_rdat", s_rdat, 8'h00);
        chk("rst_err", 8'(err), 8'd0);
        chk("rst_wreq", 8'(m_wreq), 8'd0);
        chk("rst_rreq", 8'(m_rreq), 8'd0);
        chk("rst_addr", m_addr[1], 8'h00);
        chk("rst_wdat", m_wdat[2], 8'h00);
        reset = 1'b1;
        next_cycle();

        // Directed cases.
        txn(8'h45, 1'b1, 1'b0, 8'hA5, 0, 8'h00);
        txn(8'h83, 1'b0, 1'b1, 8'h00, 3, 8'h5A);
        txn(8'hC1, 1'b0, 1'b1, 8'h00, 0, 8'h00);
        txn(8'h01, 1'b0, 1'b1, 8'h00, 0, 8'h11);
        txn(8'h41, 1'b0, 1'b1, 8'h00, 0, 8'h22);
        txn(8'hF0, 1'b1, 1'b0, 8'h3C, 0, 8'h00);
        txn(8'h7F, 1'b1, 1'b1, 8'h99, 1, 8'h66);

        // Reset while a read is held in forwarding.
        s_addr = 8'h02; s_rreq = 1'b1; m_busy = 3'b001; m_rdat = rand_rdat();
        next_cycle();
        chk("rstfwd_rreq_pre", 8'(m_rreq), 8'h01);
        reset = 1'b0;
        next_cycle();
        chk("rstfwd_rreq", 8'(m_rreq), 8'd0);
        chk("rstfwd_busy", 8'(s_busy), 8'd1);
        chk("rstfwd_rdat", s_rdat, 8'h00);
        chk("rstfwd_err", 8'(err), 8'd0);
        reset = 1'b1; s_rreq = 1'b0; m_busy = '0;
        next_cycle();
        txn(8'h02, 1'b0, 1'b1, 8'h00, 1, 8'hC3);

        // Overlapping windows: lowest index must win.
        a2_tab[0] = 8'h10; s2_tab[0] = 0;
        a2_tab[1] = 8'hC1; s2_tab[1] = 1;
        a2_tab[2] = 8'h85; s2_tab[2] = 1;
        for (int k = 0; k < 3; k++) begin
            s2_addr = a2_tab[k]; s2_rreq = 1'b1; m2_busy = '0;
            m2_rdat = rand_rdat();
            next_cycle();
            rv = 8'($urandom);
            m2_rdat[s2_tab[k]] = rv;
            chk("ovl_rreq", 8'(m2_rreq), 8'(3'(1 << s2_tab[k])));
            next_cycle();
            chk("ovl_busy", 8'(s2_busy), 8'd0);
            chk("ovl_rdat", s2_rdat, rv);
            chk("ovl_err", 8'(err2), 8'd0);
            s2_rreq = 1'b0;
            next_cycle();
        end

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            ra   = 8'($urandom);
            rw   = 8'($urandom);
            rv   = 8'($urandom);
            kind = int'($urandom_range(1, 3));
            nb   = int'($urandom_range(0, 3));
            txn(ra, kind[0], kind[1], rw, nb, rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
